// File: rtl/centroid_tracker.sv
// centroid_tracker: per-frame centroid post-processor placed after the IPU.
// It debounces target acquisition and loss, smooths the centroid with a
// shift-based exponential moving average, and hands smoothed samples to a
// consumer over valid/ready. A one-deep pending slot sits behind the output
// register; a newer result replaces an older one (latest wins).
//
// Ports:
//   iCLK, iRST         clock, asynchronous active-high reset
//   iDVAL              one-cycle frame strobe; iPresent/iRow/iCol sampled with it
//   iPresent           target present this frame
//   iRow, iCol         raw frame centroid
//   oRow, oCol, oValid smoothed sample, held stable while oValid && !iReady
//   iReady             consumer accepts the sample on oValid && iReady
//   oTracking          high while in TRACK or COAST
//   oLost              one-cycle pulse when tracking ends (COAST -> IDLE)
//   oDrop              one-cycle pulse when a valid pending sample is overwritten
module centroid_tracker #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned ACQ_FRAMES  = 2,
  parameter int unsigned LOST_FRAMES = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic             iPresent,
  input  logic [WIDTH-1:0] iRow,
  input  logic [WIDTH-1:0] iCol,
  output logic [WIDTH-1:0] oRow,
  output logic [WIDTH-1:0] oCol,
  output logic             oValid,
  input  logic             iReady,
  output logic             oTracking,
  output logic             oLost,
  output logic             oDrop
);

  localparam int unsigned ACQ_W  = $clog2(ACQ_FRAMES + 1);
  localparam int unsigned MISS_W = $clog2(LOST_FRAMES + 2);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, COAST} state_t;

  state_t              state;
  logic [ACQ_W-1:0]    acq_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [WIDTH-1:0]    s_row;
  logic [WIDTH-1:0]    s_col;

  // Frame capture registers (E0) and in-flight flag
  logic                frame;
  logic                in_present;
  logic [WIDTH-1:0]    in_row;
  logic [WIDTH-1:0]    in_col;

  // Pending slot behind the output register
  logic                pend_valid;
  logic [WIDTH-1:0]    pend_row;
  logic [WIDTH-1:0]    pend_col;

  // Next-state values evaluated at E1
  state_t              state_n;
  logic [ACQ_W-1:0]    acq_n;
  logic [MISS_W-1:0]   miss_n;
  logic [WIDTH-1:0]    s_row_n;
  logic [WIDTH-1:0]    s_col_n;
  logic [WIDTH-1:0]    ema_row;
  logic [WIDTH-1:0]    ema_col;
  logic                emit;
  logic                lost;
  logic                handshake;

  // One EMA step: s + ((x - s) >>> ALPHA_SHIFT); floor rounding keeps the result in [min(s,x), max(s,x)]
  function automatic logic [WIDTH-1:0] ema_step(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] x);
    logic signed [WIDTH:0] d;
    logic signed [WIDTH:0] sum;
    d   = $signed({1'b0, x}) - $signed({1'b0, s});
    sum = $signed({1'b0, s}) + (d >>> ALPHA_SHIFT);
    return WIDTH'(sum);
  endfunction

  assign ema_row   = ema_step(s_row, in_row);
  assign ema_col   = ema_step(s_col, in_col);
  assign handshake = oValid && iReady;

  // Acquisition/loss decision and smoothed-state update for the captured frame
  always_comb begin
    state_n = state;
    acq_n   = acq_cnt;
    miss_n  = miss_cnt;
    s_row_n = s_row;
    s_col_n = s_col;
    emit    = 1'b0;
    lost    = 1'b0;
    if (frame) begin
      unique case (state)
        IDLE: begin
          if (in_present) begin
            if (ACQ_FRAMES == 1) begin
              state_n = TRACK;
              s_row_n = in_row;
              s_col_n = in_col;
            end else begin
              state_n = ACQUIRE;
              acq_n   = ACQ_W'(1);
            end
          end
        end
        ACQUIRE: begin
          if (in_present) begin
            if (acq_cnt + ACQ_W'(1) == ACQ_W'(ACQ_FRAMES)) begin
              state_n = TRACK;
              acq_n   = '0;
              s_row_n = in_row;
              s_col_n = in_col;
              emit    = 1'b1;
            end else begin
              acq_n = acq_cnt + ACQ_W'(1);
            end
          end else begin
            state_n = IDLE;
            acq_n   = '0;
          end
        end
        TRACK: begin
          emit = 1'b1;
          if (in_present) begin
            s_row_n = ema_row;
            s_col_n = ema_col;
          end else begin
            state_n = COAST;
            miss_n  = MISS_W'(1);
          end
        end
        COAST: begin
          if (in_present) begin
            state_n = TRACK;
            miss_n  = '0;
            s_row_n = ema_row;
            s_col_n = ema_col;
            emit    = 1'b1;
          end else if (miss_cnt + MISS_W'(1) >= MISS_W'(LOST_FRAMES)) begin
            state_n = IDLE;
            miss_n  = '0;
            lost    = 1'b1;
          end else begin
            miss_n = miss_cnt + MISS_W'(1);
            emit   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame capture, FSM state, and output/pending slot management
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      acq_cnt    <= '0;
      miss_cnt   <= '0;
      s_row      <= '0;
      s_col      <= '0;
      frame      <= 1'b0;
      in_present <= 1'b0;
      in_row     <= '0;
      in_col     <= '0;
      pend_valid <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      oRow       <= '0;
      oCol       <= '0;
      oValid     <= 1'b0;
      oTracking  <= 1'b0;
      oLost      <= 1'b0;
      oDrop      <= 1'b0;
    end else begin
      oLost <= 1'b0;
      oDrop <= 1'b0;

      // A strobe while a frame is in flight is ignored
      if (frame) begin
        frame     <= 1'b0;
        state     <= state_n;
        acq_cnt   <= acq_n;
        miss_cnt  <= miss_n;
        s_row     <= s_row_n;
        s_col     <= s_col_n;
        oLost     <= lost;
        oTracking <= (state_n == TRACK) || (state_n == COAST);
      end else if (iDVAL) begin
        frame      <= 1'b1;
        in_present <= iPresent;
        in_row     <= iRow;
        in_col     <= iCol;
      end

      if (!oValid) begin
        if (emit) begin
          oRow   <= s_row_n;
          oCol   <= s_col_n;
          oValid <= 1'b1;
        end
      end else if (!handshake) begin
        if (emit) begin
          oDrop      <= pend_valid;
          pend_row   <= s_row_n;
          pend_col   <= s_col_n;
          pend_valid <= 1'b1;
        end
      end else if (pend_valid) begin
        oRow <= pend_row;
        oCol <= pend_col;
        if (emit) begin
          pend_row <= s_row_n;
          pend_col <= s_col_n;
        end else begin
          pend_valid <= 1'b0;
        end
      end else if (emit) begin
        oRow <= s_row_n;
        oCol <= s_col_n;
      end else begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed testbench for centroid_tracker with default parameters
// (WIDTH=11, ALPHA_SHIFT=2, ACQ_FRAMES=2, LOST_FRAMES=4).
module tb_centroid_tracker;

  logic        clk;
  logic        rst;
  logic        dval;
  logic        present;
  logic [10:0] row_in;
  logic [10:0] col_in;
  logic [10:0] row_out;
  logic [10:0] col_out;
  logic        valid;
  logic        ready;
  logic        tracking;
  logic        lost;
  logic        drop;

  int checks = 0;
  int errors = 0;

  centroid_tracker dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iDVAL    (dval),
    .iPresent (present),
    .iRow     (row_in),
    .iCol     (col_in),
    .oRow     (row_out),
    .oCol     (col_out),
    .oValid   (valid),
    .iReady   (ready),
    .oTracking(tracking),
    .oLost    (lost),
    .oDrop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one frame strobe; returns #1 after that frame's E1 edge
  task automatic do_frame(input logic p, input logic [10:0] r, input logic [10:0] c);
    @(posedge clk); #1;
    dval = 1'b1; present = p; row_in = r; col_in = c;
    @(posedge clk); #1;
    dval = 1'b0; present = 1'b0; row_in = '0; col_in = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dval = 1'b0; present = 1'b0; row_in = '0; col_in = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    checks++; if ({row_out, col_out} !== 22'd0) begin errors++; $display("FAIL reset_rowcol got %0d,%0d exp 0,0", row_out, col_out); end
    checks++; if ({tracking, lost, drop} !== 3'b000) begin errors++; $display("FAIL reset_flags got %03b exp 000", {tracking, lost, drop}); end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    ready = 1'b1;
    do_frame(1'b1, 11'd100, 11'd240);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL acq1_valid got %0b exp 0", valid); end
    checks++; if (tracking !== 1'b0) begin errors++; $display("FAIL acq1_tracking got %0b exp 0", tracking); end
    do_frame(1'b1, 11'd100, 11'd240);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL acq2_valid got %0b exp 1", valid); end
    checks++; if (row_out !== 11'd100 || col_out !== 11'd240) begin errors++; $display("FAIL acq2_pos got %0d,%0d exp 100,240", row_out, col_out); end
    checks++; if (tracking !== 1'b1) begin errors++; $display("FAIL acq2_tracking got %0b exp 1", tracking); end
  endtask

  task automatic test_ema();
    logic [10:0] exp_row [3];
    logic [10:0] in_rows [3];
    in_rows = '{11'd200, 11'd200, 11'd100};
    exp_row = '{11'd125, 11'd143, 11'd132};
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_frame(1'b1, in_rows[i], 11'd240);
      checks++;
      if (valid !== 1'b1 || row_out !== exp_row[i] || col_out !== 11'd240) begin
        errors++;
        $display("FAIL ema_%0d got v=%0b %0d,%0d exp v=1 %0d,240", i, valid, row_out, col_out, exp_row[i]);
      end
    end
  endtask

  task automatic test_coast_lost();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_frame(1'b0, 11'd0, 11'd0);
      checks++;
      if (valid !== 1'b1 || row_out !== 11'd132 || col_out !== 11'd240 || tracking !== 1'b1) begin
        errors++;
        $display("FAIL coast_%0d got v=%0b %0d,%0d trk=%0b exp v=1 132,240 trk=1", i, valid, row_out, col_out, tracking);
      end
    end
    do_frame(1'b0, 11'd0, 11'd0);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lost_valid got %0b exp 0", valid); end
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL lost_pulse got %0b exp 1", lost); end
    checks++; if (tracking !== 1'b0) begin errors++; $display("FAIL lost_tracking got %0b exp 0", tracking); end
    @(posedge clk); #1;
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL lost_width got %0b exp 0", lost); end
  endtask

  task automatic test_acq_abort();
    ready = 1'b1;
    do_frame(1'b1, 11'd7, 11'd7);
    do_frame(1'b0, 11'd0, 11'd0);
    checks++; if (valid !== 1'b0 || tracking !== 1'b0) begin errors++; $display("FAIL abort_idle got v=%0b trk=%0b exp 0,0", valid, tracking); end
    do_frame(1'b1, 11'd7, 11'd7);
    checks++; if (valid !== 1'b0 || tracking !== 1'b0) begin errors++; $display("FAIL abort_reacq got v=%0b trk=%0b exp 0,0", valid, tracking); end
    do_frame(1'b1, 11'd10, 11'd20);
    checks++; if (valid !== 1'b1 || row_out !== 11'd10 || col_out !== 11'd20) begin errors++; $display("FAIL abort_seed got v=%0b %0d,%0d exp v=1 10,20", valid, row_out, col_out); end
  endtask

  task automatic test_backpressure();
    // Smoothed rows from seed 10: 30 -> 15, 31 -> 19, 59 -> 29
    @(posedge clk); #1;
    ready = 1'b0;
    do_frame(1'b1, 11'd30, 11'd20);
    checks++; if (valid !== 1'b1 || row_out !== 11'd15 || drop !== 1'b0) begin errors++; $display("FAIL bp_a got v=%0b row=%0d drop=%0b exp 1,15,0", valid, row_out, drop); end
    do_frame(1'b1, 11'd31, 11'd20);
    checks++; if (row_out !== 11'd15 || drop !== 1'b0) begin errors++; $display("FAIL bp_b got row=%0d drop=%0b exp 15,0", row_out, drop); end
    do_frame(1'b1, 11'd59, 11'd20);
    checks++; if (row_out !== 11'd15 || col_out !== 11'd20 || drop !== 1'b1) begin errors++; $display("FAIL bp_c got %0d,%0d drop=%0b exp 15,20,1", row_out, col_out, drop); end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL bp_drop_width got %0b exp 0", drop); end
    checks++; if (valid !== 1'b1 || row_out !== 11'd29 || col_out !== 11'd20) begin errors++; $display("FAIL bp_pend got v=%0b %0d,%0d exp 1 29,20", valid, row_out, col_out); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", valid); end
  endtask

  task automatic test_reset_mid_coast();
    ready = 1'b0;
    do_frame(1'b0, 11'd0, 11'd0);
    checks++; if (valid !== 1'b1 || row_out !== 11'd29 || tracking !== 1'b1) begin errors++; $display("FAIL mc_coast got v=%0b row=%0d trk=%0b exp 1,29,1", valid, row_out, tracking); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({valid, tracking, lost, drop} !== 4'b0000 || {row_out, col_out} !== 22'd0) begin
      errors++; $display("FAIL mc_async got v=%0b trk=%0b %0d,%0d exp all 0", valid, tracking, row_out, col_out);
    end
    #2 rst = 1'b0;
    ready = 1'b1;
    do_frame(1'b1, 11'd5, 11'd5);
    checks++; if (valid !== 1'b0 || tracking !== 1'b0) begin errors++; $display("FAIL mc_restart got v=%0b trk=%0b exp 0,0", valid, tracking); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_ema();
    test_coast_lost();
    test_acq_abort();
    test_backpressure();
    test_reset_mid_coast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
